// File: rtl/fibo_pkg.sv
// Shared types and constants for the bounded Fibonacci sequencer.
package fibo_pkg;

    localparam int unsigned FIBO_WIDTH = 4;
    localparam int unsigned FIBO_CNT_W = 4;

    // reg_a holds F(k+1), reg_b holds F(k)
    localparam int unsigned FIBO_A_INIT = 1;
    localparam int unsigned FIBO_B_INIT = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } fibo_state_e;

endpackage

// File: rtl/fibo_datapath.sv
// Fibonacci term registers and ripple adder; carry-out is registered with reg_a.
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int unsigned WIDTH = FIBO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             advance,
    output logic [WIDTH-1:0] term,
    output logic             carry
);

    logic [WIDTH-1:0] reg_a_q;
    logic [WIDTH-1:0] reg_b_q;
    logic             carry_q;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, reg_a_q} + {1'b0, reg_b_q};

    always_ff @(posedge clk) begin
        if (!reset || init) begin
            reg_a_q <= WIDTH'(FIBO_A_INIT);
            reg_b_q <= WIDTH'(FIBO_B_INIT);
            carry_q <= 1'b0;
        end else if (advance) begin
            reg_b_q <= reg_a_q;
            reg_a_q <= sum[WIDTH-1:0];
            carry_q <= sum[WIDTH];
        end
    end

    assign term  = reg_b_q;
    assign carry = carry_q;

endmodule

// File: rtl/fibo_seq_ctrl.sv
// Bounded, flow-controlled Fibonacci sequencer: FSM, term counter and sticky overflow flag.
module fibo_seq_ctrl
    import fibo_pkg::*;
#(
    parameter int unsigned WIDTH = FIBO_WIDTH,
    parameter int unsigned CNT_W = FIBO_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             term_ready,
    output logic [WIDTH-1:0] term_out,
    output logic             term_valid,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    fibo_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] n_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;

    logic             dp_init;
    logic             dp_advance;
    logic             carry;
    logic             xfer;
    logic             last;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign xfer       = (state_q == StRun) && term_ready;
    assign last       = (cnt_inc == n_q);
    assign dp_init    = (state_q == StIdle) && start;
    assign dp_advance = xfer && !last && !carry;

    fibo_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .init   (dp_init),
        .advance(dp_advance),
        .term   (term_out),
        .carry  (carry)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            n_q        <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        n_q        <= n_terms;
                        cnt_q      <= '0;
                        overflow_q <= 1'b0;
                        if (n_terms == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        // Count limit takes priority over a pending carry
                        if (last || carry) begin
                            state_q    <= StDone;
                            valid_q    <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            overflow_q <= !last;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign term_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// Scoreboard bench for fibo_seq_ctrl: expected terms and done/overflow events are queued
// by the stimulus and consumed by an independent monitor.
module tb_fibo_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] n_terms;
    logic       term_ready;
    logic [3:0] term_out;
    logic       term_valid;
    logic       busy;
    logic       done;
    logic       overflow;

    int checks;
    int errors;

    int exp_terms[$];
    bit exp_ovf[$];

    // Hand-computed WIDTH=4 series
    int fib_tab[8] = '{0, 1, 1, 2, 3, 5, 8, 13};

    logic       stalled_prev;
    logic [3:0] prev_term;

    fibo_seq_ctrl #(
        .WIDTH(4),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_terms   (n_terms),
        .term_ready(term_ready),
        .term_out  (term_out),
        .term_valid(term_valid),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops and compares on every transfer and every done pulse
    initial begin
        stalled_prev = 1'b0;
        prev_term    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (stalled_prev && term_valid) begin
                    check("stall_stable", int'(term_out), int'(prev_term));
                end
                if (term_valid && term_ready) begin
                    if (exp_terms.size() == 0) begin
                        check("unexpected_term", int'(term_out), -1);
                    end else begin
                        check("term", int'(term_out), exp_terms.pop_front());
                    end
                end
                if (done) begin
                    if (exp_ovf.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        check("done_overflow", int'(overflow), int'(exp_ovf.pop_front()));
                    end
                    check("done_busy_valid", int'({busy, term_valid}), 0);
                end
                stalled_prev = term_valid && !term_ready;
                prev_term    = term_out;
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int n, input bit ovf);
        for (int i = 0; i < n; i++) exp_terms.push_back(fib_tab[i]);
        exp_ovf.push_back(ovf);
    endtask

    task automatic start_run(input int n);
        start   = 1'b1;
        n_terms = 4'(n);
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            step();
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    int cyc;
    int ready_pat[7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        start      = 1'b0;
        n_terms    = '0;
        term_ready = 1'b0;
        step();
        step();
        check("reset_outputs", int'({term_out, term_valid, busy, done, overflow}), 0);
        reset = 1'b1;
        step();

        // Reset mid-run after two accepted terms
        term_ready = 1'b1;
        exp_terms.push_back(0);
        exp_terms.push_back(1);
        start_run(5);
        check("run_valid_first", int'({term_valid, busy}), 3);
        step();
        step();
        reset = 1'b0;
        step();
        check("midrun_reset_outputs", int'({term_out, term_valid, busy, done, overflow}), 0);
        reset = 1'b1;
        step();
        check("after_reset_idle", int'({term_valid, busy, done}), 0);

        // Bounded run restarts from 0
        push_run(5, 1'b0);
        start_run(5);
        wait_done(40, cyc);
        check("bounded_latency", cyc, 5);
        step();
        check("bounded_idle_ovf", int'(overflow), 0);

        // Overflow run: stops after 13
        push_run(8, 1'b1);
        start_run(12);
        wait_done(40, cyc);
        check("ovf_latency", cyc, 8);
        step();
        check("ovf_idle_sticky", int'({overflow, busy, done}), 4);
        step();
        step();
        check("ovf_idle_sticky_later", int'(overflow), 1);

        // Count limit coincides with carry: count wins, overflow cleared by start
        push_run(8, 1'b0);
        start_run(8);
        check("ovf_cleared_on_start", int'(overflow), 0);
        wait_done(40, cyc);
        check("n8_latency", cyc, 8);
        step();

        // Backpressure with an ignored start during RUN
        push_run(4, 1'b0);
        start_run(4);
        for (int i = 0; i < 7; i++) begin
            term_ready = ready_pat[i][0];
            if (i == 2) begin
                start   = 1'b1;
                n_terms = 4'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start      = 1'b0;
        term_ready = 1'b1;
        check("bp_done_after_pattern", int'(done), 1);
        wait_done(40, cyc);
        step();
        check("bp_idle", int'({term_valid, busy, done}), 0);

        // n_terms = 0: immediate done, no terms
        exp_ovf.push_back(1'b0);
        start_run(0);
        check("n0_done", int'({done, term_valid, busy}), 4);
        step();
        check("n0_idle", int'({done, term_valid}), 0);
        step();
        step();

        check("terms_left", exp_terms.size(), 0);
        check("dones_left", exp_ovf.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fibo_seq_ctrl.md
# fibo_seq_ctrl

Sequencing controller for the Fibonacci datapath (ripple-carry adder plus two term registers). It accepts a start request with a requested term count, runs the datapath one term per accepted transfer over a valid/ready output, and stops on count exhaustion or adder carry-out. It reports completion with a one-cycle `done` pulse and a sticky `overflow` flag. The block sits between a host/test sequencer and the series datapath, replacing the free-running generator with a bounded, flow-controlled one.

## Interface
- `WIDTH`, 4: term width in bits; adder and both term registers.
- `CNT_W`, 4: width of `n_terms` and the internal emitted-term counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on the `clk` rising edge.
- `start` input 1: run request; honoured only in IDLE.
- `n_terms` input CNT_W: number of terms to emit; sampled with `start`.
- `term_ready` input 1: consumer accepts `term_out` when high with `term_valid`.
- `term_out` output WIDTH: current term F(k).
- `term_valid` output 1: `term_out` valid.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle completion pulse.
- `overflow` output 1: the run ended because the next term was unrepresentable; sticky until the next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
- **Reset** (`reset`=0 at an edge): state=IDLE; reg_a=1 (holds F(k+1)), reg_b=0 (holds F(k)); cnt=0; carry_q=0. All outputs are 0: `term_out`=0, `term_valid`=0, `busy`=0, `done`=0, `overflow`=0. Reset wins over every other input, including mid-RUN.
- **IDLE, `start`=1:**
  - Latch `n_terms`.
  - Load reg_a=1, reg_b=0, cnt=0, carry_q=0; clear `overflow`.
  - If `n_terms`=0, go to DONE and emit no terms. Otherwise go to RUN.
- **IDLE, `start`=0:** hold.
- **RUN:**
  - `term_valid`=1 and `term_out`=reg_b.
  - No transfer (`term_ready`=0): all state holds and `term_out` stays stable.
  - **On a transfer** (`term_valid`&`term_ready`):
    - If cnt+1 == latched `n_terms`, go to DONE.
    - Else if carry_q=1, set `overflow`=1 and go to DONE. (reg_a holds a wrapped value.)
    - Else advance: reg_b<=reg_a, reg_a<=sum(reg_a+reg_b) mod 2^WIDTH, carry_q<=adder cout, cnt<=cnt+1; stay in RUN.
  - When the count limit and carry_q=1 coincide, the run completes by count: `overflow` stays 0.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. `term_valid`=0.
- `start` is ignored in RUN and DONE. It has no effect and is not queued.
- Arithmetic: the adder is unsigned WIDTH-bit. Carry-out is registered as carry_q alongside reg_a, so the overflow decision needs no combinational path from adder to `term_valid`.

## Timing
- `start` accepted at edge t puts RUN at t+1, with `term_valid`=1 and `term_out`=0 in that cycle.
- Throughput is one term per cycle while `term_ready`=1. A transfer at edge e presents the next term at e+1.
- The last transfer at edge e gives DONE (`done`=1, `busy`=0) during cycle e+1 and IDLE at e+2. A new `start` is accepted in IDLE at e+2 at the earliest.
- With `n_terms`=0, start at edge t gives DONE during t+1.
- `overflow` is valid from the DONE cycle onward and holds through IDLE.
- WIDTH=4 emits at most 8 terms: 0,1,1,2,3,5,8,13. The advance after 13 computes 21, which sets carry_q and leaves reg_a=5.

## Structure
- Package `fibo_pkg`:
  - state enum (IDLE/RUN/DONE);
  - default WIDTH/CNT_W;
  - reset constants FIBO_A_INIT=1, FIBO_B_INIT=0.
- Sub-module `fibo_datapath`:
  - adder plus reg_a/reg_b/carry_q;
  - `init` and `advance` enables;
  - `term`=reg_b output;
  - uses the same synchronous active-low `reset`.
- The FSM, counter and `overflow` flag live in `fibo_seq_ctrl`.

## Test plan
- Reset mid-run: start, `n_terms`=5, `term_ready`=1, then `reset`=0 after 2 terms. Required: next cycle all outputs 0, state IDLE. A subsequent start emits from 0 again.
- Bounded run: `n_terms`=5, `term_ready`=1. Required: `term_out` 0,1,1,2,3 on consecutive cycles, then one `done` cycle, `overflow`=0.
- Overflow: `n_terms`=12, `term_ready`=1. Required: 0,1,1,2,3,5,8,13 (8 terms), then `done` with `overflow`=1; `overflow` still 1 in IDLE until the next `start`.
- Backpressure: `n_terms`=4, `term_ready` toggling 1,0,0,1,0,1,1. Required: `term_out` stable while stalled; accepted sequence 0,1,1,2; `start` pulsed during RUN is ignored.
- Edge counts: `n_terms`=0 gives `done` one cycle after `start` with no `term_valid`. `n_terms`=8 gives 8 terms ending at 13, with `overflow`=0 (count wins over carry).
